// File: rtl/vgpr_wr_arbiter_if.sv
// Bundles the VGPR write-port arbitration bus.
// Ports:
//   port_req[7:0]        requester -> arbiter, one bit per write requester
//   port_last[7:0]       requester -> arbiter, final beat of the current burst
//   wr_stall             register file -> arbiter, no write accepted next cycle
//   port_grant[7:0]      arbiter -> requesters, registered one-hot grant
//   wr_port_select[15:0] arbiter -> write-port mux, {8'h00, port_grant}
//   arb_locked           arbiter -> observers, burst lock held
//   burst_err            arbiter -> observers, watchdog force-release pulse
interface vgpr_wr_arbiter_if;
    localparam int unsigned NUM_PORTS = 8;
    localparam int unsigned SEL_W     = 16;

    logic [NUM_PORTS-1:0] port_req;
    logic [NUM_PORTS-1:0] port_last;
    logic                 wr_stall;
    logic [NUM_PORTS-1:0] port_grant;
    logic [SEL_W-1:0]     wr_port_select;
    logic                 arb_locked;
    logic                 burst_err;

    // Requester / register-file side.
    modport master (
        output port_req,
        output port_last,
        output wr_stall,
        input  port_grant,
        input  wr_port_select,
        input  arb_locked,
        input  burst_err
    );

    // Arbiter side.
    modport slave (
        input  port_req,
        input  port_last,
        input  wr_stall,
        output port_grant,
        output wr_port_select,
        output arb_locked,
        output burst_err
    );
endinterface

// File: rtl/vgpr_wr_arbiter.sv
// Round-robin arbiter for the single VGPR write port shared by eight
// requesters, with multi-beat locked bursts, a register-file stall and a
// burst-length watchdog.
// Ports:
//   clk  clock, rising edge
//   rst  asynchronous active-high reset
//   bus  vgpr_wr_arbiter_if.slave: port_req/port_last/wr_stall in,
//        port_grant/wr_port_select/arb_locked/burst_err out (all from flops)
module vgpr_wr_arbiter #(
    parameter int unsigned MAX_BURST = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    vgpr_wr_arbiter_if.slave     bus
);
    localparam int unsigned NUM_PORTS = 8;
    localparam int unsigned PTR_W     = 3;
    localparam int unsigned CNT_W     = 8;
    localparam int unsigned HI_W      = 8;

    typedef enum logic {
        ST_OPEN   = 1'b0,
        ST_LOCKED = 1'b1
    } lock_state_e;

    lock_state_e          state_q,   state_d;
    logic [PTR_W-1:0]     lock_id_q, lock_id_d;
    logic [PTR_W-1:0]     rr_q,      rr_d;
    logic [CNT_W-1:0]     beat_q,    beat_d;
    logic [NUM_PORTS-1:0] grant_q,   grant_d;
    logic                 err_q,     err_d;

    logic [PTR_W-1:0]     rr_win;
    logic                 rr_found;
    logic [PTR_W-1:0]     cand;
    logic [PTR_W-1:0]     win_id;
    logic                 win_valid;
    logic [CNT_W-1:0]     beat_inc;

    // First requester at or after rr_q; 3-bit add wraps 7 -> 0.
    always_comb begin
        rr_found = 1'b0;
        rr_win   = rr_q;
        cand     = rr_q;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            cand = rr_q + PTR_W'(i);
            if (!rr_found && bus.port_req[cand]) begin
                rr_found = 1'b1;
                rr_win   = cand;
            end
        end
    end

    // Lock state, pointer, beat counter and next grant.
    always_comb begin
        state_d   = state_q;
        lock_id_d = lock_id_q;
        rr_d      = rr_q;
        beat_d    = beat_q;
        grant_d   = '0;
        err_d     = 1'b0;
        win_valid = 1'b0;
        win_id    = lock_id_q;
        beat_inc  = beat_q + CNT_W'(1);

        // A stall freezes everything, including a pending last beat.
        if (!bus.wr_stall) begin
            if (state_q == ST_LOCKED) begin
                win_valid = bus.port_req[lock_id_q];
                win_id    = lock_id_q;
            end else begin
                win_valid = rr_found;
                win_id    = rr_win;
            end

            if (win_valid) begin
                grant_d = NUM_PORTS'(1) << win_id;
                if (bus.port_last[win_id]) begin
                    state_d = ST_OPEN;
                    rr_d    = win_id + PTR_W'(1);
                    beat_d  = '0;
                end else if (beat_inc == CNT_W'(MAX_BURST)) begin
                    // Watchdog: drop the lock; the port's remaining beats re-arbitrate.
                    state_d = ST_OPEN;
                    rr_d    = win_id + PTR_W'(1);
                    beat_d  = '0;
                    err_d   = 1'b1;
                end else begin
                    state_d   = ST_LOCKED;
                    lock_id_d = win_id;
                    beat_d    = beat_inc;
                end
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_OPEN;
            lock_id_q <= '0;
            rr_q      <= '0;
            beat_q    <= '0;
            grant_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            lock_id_q <= lock_id_d;
            rr_q      <= rr_d;
            beat_q    <= beat_d;
            grant_q   <= grant_d;
            err_q     <= err_d;
        end
    end

    assign bus.port_grant     = grant_q;
    assign bus.wr_port_select = {HI_W'(0), grant_q};
    assign bus.arb_locked     = (state_q == ST_LOCKED);
    assign bus.burst_err      = err_q;
endmodule

// File: tb/tb_vgpr_wr_arbiter.sv
// Directed bench for vgpr_wr_arbiter with MAX_BURST=4: reset, round robin,
// burst lock, stall/bubble, watchdog and sparse wrap.
module tb_vgpr_wr_arbiter;
    localparam int unsigned MAX_BURST = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    vgpr_wr_arbiter_if bus();

    vgpr_wr_arbiter #(.MAX_BURST(MAX_BURST)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [7:0] g, input logic lk, input logic er);
        check_eq({tag, ".grant"}, 16'(bus.port_grant), 16'(g));
        check_eq({tag, ".sel"},   bus.wr_port_select,  {8'h00, g});
        check_eq({tag, ".lock"},  16'(bus.arb_locked), 16'(lk));
        check_eq({tag, ".err"},   16'(bus.burst_err),  16'(er));
    endtask

    // Apply inputs, clock once, check the registered outputs 1ns after the edge.
    task automatic cyc(input string tag, input logic [7:0] req, input logic [7:0] last,
                       input logic stall, input logic [7:0] g, input logic lk, input logic er);
        bus.port_req  = req;
        bus.port_last = last;
        bus.wr_stall  = stall;
        @(posedge clk);
        #1;
        check_outs(tag, g, lk, er);
    endtask

    initial begin
        logic [7:0] g;
        rst           = 1'b1;
        bus.port_req  = '0;
        bus.port_last = '0;
        bus.wr_stall  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_outs("reset", 8'h00, 1'b0, 1'b0);
        rst = 1'b0;

        // Lock on port 3, then reset asynchronously mid-cycle.
        cyc("lk3a", 8'h08, 8'h00, 1'b0, 8'h08, 1'b1, 1'b0);
        cyc("lk3b", 8'hFF, 8'h00, 1'b0, 8'h08, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1 check_outs("async_rst", 8'h00, 1'b0, 1'b0);
        #2 rst = 1'b0;

        // Round robin from port 0 after reset.
        for (int i = 0; i < 16; i++) begin
            g = 8'h01 << (i % 8);
            cyc($sformatf("rr%0d", i), 8'hFF, 8'hFF, 1'b0, g, 1'b0, 1'b0);
        end
        cyc("idle0", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);

        // Burst lock: port 5 four beats while 2 and 6 wait (rr_ptr moved to 5 first).
        cyc("bl_pre", 8'h10, 8'h10, 1'b0, 8'h10, 1'b0, 1'b0);
        cyc("bl1",    8'h64, 8'h44, 1'b0, 8'h20, 1'b1, 1'b0);
        cyc("bl2",    8'h64, 8'h44, 1'b0, 8'h20, 1'b1, 1'b0);
        cyc("bl3",    8'h64, 8'h44, 1'b0, 8'h20, 1'b1, 1'b0);
        cyc("bl4",    8'h64, 8'h64, 1'b0, 8'h20, 1'b0, 1'b0);
        cyc("bl5",    8'h44, 8'h44, 1'b0, 8'h40, 1'b0, 1'b0);
        cyc("bl6",    8'h04, 8'h04, 1'b0, 8'h04, 1'b0, 1'b0);
        cyc("idle1",  8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);

        // Stall and bubble during a port 1 burst with port 4 waiting.
        cyc("sb_pre", 8'h01, 8'h01, 1'b0, 8'h01, 1'b0, 1'b0);
        cyc("sb1",    8'h12, 8'h10, 1'b0, 8'h02, 1'b1, 1'b0);
        cyc("sb2",    8'h12, 8'h10, 1'b1, 8'h00, 1'b1, 1'b0);
        cyc("sb3",    8'h12, 8'h12, 1'b1, 8'h00, 1'b1, 1'b0);
        cyc("sb4",    8'h10, 8'h10, 1'b0, 8'h00, 1'b1, 1'b0);
        cyc("sb5",    8'h12, 8'h12, 1'b0, 8'h02, 1'b0, 1'b0);
        cyc("sb6",    8'h10, 8'h10, 1'b0, 8'h10, 1'b0, 1'b0);

        // Watchdog: port 7 never sends last, port 0 waiting.
        cyc("wd1", 8'h81, 8'h01, 1'b0, 8'h80, 1'b1, 1'b0);
        cyc("wd2", 8'h81, 8'h01, 1'b0, 8'h80, 1'b1, 1'b0);
        cyc("wd3", 8'h81, 8'h01, 1'b0, 8'h80, 1'b1, 1'b0);
        cyc("wd4", 8'h81, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        cyc("wd5", 8'h81, 8'h01, 1'b0, 8'h01, 1'b0, 1'b0);
        cyc("wd6", 8'h81, 8'h01, 1'b0, 8'h80, 1'b1, 1'b0);
        cyc("wd7", 8'h81, 8'h81, 1'b0, 8'h80, 1'b0, 1'b0);

        // Sparse wrap: rr_ptr brought to 7, then ports 7 and 0 alternate.
        cyc("sp_pre", 8'h40, 8'h40, 1'b0, 8'h40, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            g = (i % 2 == 0) ? 8'h80 : 8'h01;
            cyc($sformatf("sp%0d", i), 8'h81, 8'h81, 1'b0, g, 1'b0, 1'b0);
        end
        cyc("idle2", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
